data_loader_wb_writer: RTL and testbench

- Downstream stage of the APF data loader. It consumes the loader's single-cycle write strobes in the memory clock domain and issues them as Wishbone B4 classic single-word writes into LiteX main memory.
- The loader has no backpressure, so this block buffers writes in a small FIFO.
- It sequences one bus transaction at a time, with a watchdog, and reports sticky overflow and error flags to the core's status logic.

---
 rtl/data_loader_pkg.sv | 26 ++
 rtl/data_loader_fifo.sv | 72 +++++++
 rtl/data_loader_wb_writer.sv | 191 +++++++++++++++++++
 tb/tb_data_loader_wb_writer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_loader_pkg.sv
// -----------------------------------------------------------------------------
// data_loader_pkg
// Shared types and constants for the APF data loader Wishbone writer.
//   wb_state_e      : bus sequencer states (IDLE, WRITE)
//   SEL_ALL         : byte-select value for full-word writes
//   COUNT_WIDTH     : width of the completed-write counter
//   timeout_width() : bits needed to hold a watchdog count of TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
package data_loader_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wb_state_e;

   localparam logic [3:0] SEL_ALL     = 4'hF;
   localparam int         COUNT_WIDTH = 16;

   // Width of a counter that must be able to hold the value timeout_cycles.
   function automatic int timeout_width(input int timeout_cycles);
      int w;
      w = $clog2(timeout_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/data_loader_fifo.sv
// -----------------------------------------------------------------------------
// data_loader_fifo
// Single-clock synchronous FIFO with first-word-fall-through head output.
// A push is accepted when the FIFO is not full, or when a pop happens on the
// same edge (the freed slot is reused, so the count stays unchanged).
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, empties the FIFO
//   push_i  : write request
//   data_i  : write data
//   pop_i   : remove the head entry (ignored when empty)
//   head_o  : current head entry, valid while empty_o is low
//   full_o  : registered full flag
//   empty_o : registered empty flag
// -----------------------------------------------------------------------------
module data_loader_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, empty_q;
   logic             accept, take;

   assign accept  = push_i & (~full_q | pop_i);
   assign take    = pop_i & ~empty_q;
   assign count_d = count_q + CNT_W'(accept) - CNT_W'(take);

   // NOTE: storage is deliberately left out of reset; only the pointers and
   // flags define which entries are valid, and a reset array costs a mux per bit.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // NOTE: every register here is updated with <= so all of them see the
   // pre-edge values of each other, exactly like the hardware flops.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (take)   rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/data_loader_wb_writer.sv
// -----------------------------------------------------------------------------
// data_loader_wb_writer
// Buffers the loader's single-cycle write strobes and replays them as
// Wishbone B4 classic single-word writes, one transaction at a time, with a
// watchdog on every transaction.
//   clk_memory      : memory clock, only clock in the block
//   reset           : asynchronous active-high reset
//   write_en        : one-cycle write strobe from the loader
//   write_addr      : byte address, qualified by write_en
//   write_data      : data word, qualified by write_en
//   wb_cyc/wb_stb   : Wishbone cycle / strobe
//   wb_we           : Wishbone write enable (high with wb_cyc)
//   wb_adr          : Wishbone word address
//   wb_dat_w        : Wishbone write data
//   wb_sel          : byte selects
//   wb_ack/wb_err   : Wishbone responses
//   busy            : FIFO non-empty or a transaction in progress
//   overflow        : sticky, a write was dropped because the FIFO was full
//   error           : sticky, a transaction ended with wb_err or a timeout
//   completed_count : number of acked writes, wraps at 16 bits
// -----------------------------------------------------------------------------
module data_loader_wb_writer
   import data_loader_pkg::*;
#(
   parameter int                      ADDRESS_SIZE   = 28,
   parameter int                      FIFO_DEPTH     = 8,
   parameter int                      WB_ADR_WIDTH   = 30,
   parameter logic [WB_ADR_WIDTH-1:0] WB_BASE_WORD   = '0,
   parameter int                      BYTE_SWAP      = 0,
   parameter int                      TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_memory,
   input  logic                    reset,
   input  logic                    write_en,
   input  logic [ADDRESS_SIZE-1:0] write_addr,
   input  logic [31:0]             write_data,
   output logic                    wb_cyc,
   output logic                    wb_stb,
   output logic                    wb_we,
   output logic [WB_ADR_WIDTH-1:0] wb_adr,
   output logic [31:0]             wb_dat_w,
   output logic [3:0]              wb_sel,
   input  logic                    wb_ack,
   input  logic                    wb_err,
   output logic                    busy,
   output logic                    overflow,
   output logic                    error,
   output logic [15:0]             completed_count
);

   localparam int ENTRY_W = ADDRESS_SIZE + 32;
   localparam int TMO_W   = timeout_width(TIMEOUT_CYCLES);
   // The counter is cleared at the start edge and advances once per waiting
   // edge, so it reaches TIMEOUT_CYCLES on the edge after it holds this value.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------- buffer
   logic [ENTRY_W-1:0]      fifo_head;
   logic                    fifo_full, fifo_empty;
   logic                    pop;
   logic [ADDRESS_SIZE-1:0] head_addr;
   logic [31:0]             head_data;

   data_loader_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_memory),
      .rst_i   (reset),
      .push_i  (write_en),
      .data_i  ({write_addr, write_data}),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_addr = fifo_head[ENTRY_W-1:32];
   assign head_data = fifo_head[31:0];

   // ------------------------------------------------------ head conversion
   logic [WB_ADR_WIDTH-1:0] adr_conv;
   logic [31:0]             dat_conv;

   // Byte address to word address; the sum wraps at the bus address width.
   assign adr_conv = WB_ADR_WIDTH'(head_addr >> 2) + WB_BASE_WORD;
   assign dat_conv = (BYTE_SWAP != 0)
                   ? {head_data[7:0], head_data[15:8], head_data[23:16], head_data[31:24]}
                   : head_data;

   // ------------------------------------------------------------ sequencer
   wb_state_e               state_q, state_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic                    cyc_q, cyc_d;
   logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
   logic [31:0]             dat_q, dat_d;
   logic [3:0]              sel_q, sel_d;
   logic [COUNT_WIDTH-1:0]  count_q, count_d;
   logic                    overflow_q, overflow_d;
   logic                    error_q, error_d;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      cyc_d   = cyc_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      count_d = count_q;
      error_d = error_q;
      pop     = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Responses seen while idle are stale and ignored.
            if (!fifo_empty) begin
               adr_d   = adr_conv;
               dat_d   = dat_conv;
               sel_d   = SEL_ALL;
               cyc_d   = 1'b1;
               tmo_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            // The head stays in the FIFO until the transaction ends.
            if (wb_err) begin
               pop     = 1'b1;
               error_d = 1'b1;
               cyc_d   = 1'b0;
               state_d = IDLE;
            end else if (wb_ack) begin
               pop     = 1'b1;
               count_d = count_q + COUNT_WIDTH'(1);
               cyc_d   = 1'b0;
               state_d = IDLE;
            end else if (tmo_q == TMO_LAST) begin
               pop     = 1'b1;
               error_d = 1'b1;
               cyc_d   = 1'b0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A push into a full FIFO is lost unless the same edge frees a slot.
      overflow_d = overflow_q | (write_en & fifo_full & ~pop);
   end

   always_ff @(posedge clk_memory or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tmo_q      <= '0;
         cyc_q      <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         cyc_q      <= cyc_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         sel_q      <= sel_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         error_q    <= error_d;
      end
   end

   // cyc, stb and we always move together, so one flop drives all three.
   assign wb_cyc          = cyc_q;
   assign wb_stb          = cyc_q;
   assign wb_we           = cyc_q;
   assign wb_adr          = adr_q;
   assign wb_dat_w        = dat_q;
   assign wb_sel          = sel_q;
   assign busy            = ~fifo_empty | (state_q != IDLE);
   assign overflow        = overflow_q;
   assign error           = error_q;
   assign completed_count = count_q;

endmodule

// File: tb/tb_data_loader_wb_writer.sv
// -----------------------------------------------------------------------------
// tb_data_loader_wb_writer
// Two writers (default parameters, and byte-swapped with a 0x1000 word base)
// share one stimulus and one Wishbone slave model. A queue-based reference
// model predicts every output; a compare process checks it each cycle, and
// directed sequences pin literal values.
// -----------------------------------------------------------------------------
module tb_data_loader_wb_writer;

   localparam int          A_SZ   = 28;
   localparam int          DEPTH  = 8;
   localparam int          TMO    = 255;
   localparam logic [29:0] BASE_A = 30'h0;
   localparam logic [29:0] BASE_B = 30'h1000;

   logic            clk_memory = 1'b0;
   logic            reset      = 1'b0;
   logic            write_en   = 1'b0;
   logic [A_SZ-1:0] write_addr = '0;
   logic [31:0]     write_data = '0;
   logic            wb_ack     = 1'b0;
   logic            wb_err     = 1'b0;

   logic        cyc_a, stb_a, we_a, busy_a, ovf_a, err_a;
   logic [29:0] adr_a;
   logic [31:0] dat_a;
   logic [3:0]  sel_a;
   logic [15:0] cnt_a;
   logic        cyc_b, stb_b, we_b, busy_b, ovf_b, err_b;
   logic [29:0] adr_b;
   logic [31:0] dat_b;
   logic [3:0]  sel_b;
   logic [15:0] cnt_b;

   always #5 clk_memory = ~clk_memory;

   data_loader_wb_writer #(
      .ADDRESS_SIZE(A_SZ), .FIFO_DEPTH(DEPTH), .WB_ADR_WIDTH(30),
      .WB_BASE_WORD(BASE_A), .BYTE_SWAP(0), .TIMEOUT_CYCLES(TMO)
   ) dut_a (
      .clk_memory(clk_memory), .reset(reset), .write_en(write_en),
      .write_addr(write_addr), .write_data(write_data),
      .wb_cyc(cyc_a), .wb_stb(stb_a), .wb_we(we_a), .wb_adr(adr_a),
      .wb_dat_w(dat_a), .wb_sel(sel_a), .wb_ack(wb_ack), .wb_err(wb_err),
      .busy(busy_a), .overflow(ovf_a), .error(err_a), .completed_count(cnt_a)
   );

   data_loader_wb_writer #(
      .ADDRESS_SIZE(A_SZ), .FIFO_DEPTH(DEPTH), .WB_ADR_WIDTH(30),
      .WB_BASE_WORD(BASE_B), .BYTE_SWAP(1), .TIMEOUT_CYCLES(TMO)
   ) dut_b (
      .clk_memory(clk_memory), .reset(reset), .write_en(write_en),
      .write_addr(write_addr), .write_data(write_data),
      .wb_cyc(cyc_b), .wb_stb(stb_b), .wb_we(we_b), .wb_adr(adr_b),
      .wb_dat_w(dat_b), .wb_sel(sel_b), .wb_ack(wb_ack), .wb_err(wb_err),
      .busy(busy_b), .overflow(ovf_b), .error(err_b), .completed_count(cnt_b)
   );

   // ---------------------------------------------------------------- checking
   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [29:0] conv_adr(input logic [A_SZ-1:0] a, input logic [29:0] base);
      return 30'((32'(a) >> 2) + 32'(base));
   endfunction

   function automatic logic [31:0] swap_bytes(input logic [31:0] d);
      logic [31:0] s;
      s = {<<8{d}};
      return s;
   endfunction

   // ---------------------------------------------------------------- model
   typedef struct packed {
      logic [A_SZ-1:0] addr;
      logic [31:0]     data;
   } entry_t;

   entry_t      m_q[$];
   entry_t      m_cur;
   bit          m_in_flight = 1'b0;
   int          m_waited    = 0;
   int unsigned m_done      = 0;
   bit          m_ovf       = 1'b0;
   bit          m_err       = 1'b0;

   task automatic model_reset();
      m_q.delete();
      m_in_flight = 1'b0;
      m_waited    = 0;
      m_done      = 0;
      m_ovf       = 1'b0;
      m_err       = 1'b0;
   endtask

   // One clock edge: finish or start a transaction, then take the new write.
   task automatic model_step();
      bit     ending;
      entry_t e;
      ending = 1'b0;
      if (m_in_flight) begin
         m_waited++;
         if (wb_err)                 begin m_err = 1'b1; ending = 1'b1; end
         else if (wb_ack)            begin m_done++;     ending = 1'b1; end
         else if (m_waited == TMO)   begin m_err = 1'b1; ending = 1'b1; end
      end else if (m_q.size() != 0) begin
         m_cur       = m_q[0];
         m_in_flight = 1'b1;
         m_waited    = 0;
      end
      if (ending) begin
         void'(m_q.pop_front());
         m_in_flight = 1'b0;
      end
      if (write_en) begin
         e.addr = write_addr;
         e.data = write_data;
         if (m_q.size() < DEPTH) m_q.push_back(e);
         else                    m_ovf = 1'b1;
      end
   endtask

   initial forever begin
      @(posedge clk_memory or posedge reset);
      if (reset) model_reset();
      else       model_step();
   end

   // ---------------------------------------------------------------- compare
   bit          chk_en   = 1'b0;
   bit          prev_cyc = 1'b0;
   logic [31:0] issued[$];

   task automatic cmp_dut(input string t,
                          input logic cyc, input logic stb, input logic we,
                          input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic bsy, input logic ovf, input logic err, input logic [15:0] cnt,
                          input logic [29:0] e_adr, input logic [31:0] e_dat);
      check({t, ".cyc"},   cyc, m_in_flight);
      check({t, ".stb"},   stb, m_in_flight);
      check({t, ".we"},    we,  m_in_flight);
      check({t, ".busy"},  bsy, (m_q.size() != 0) || m_in_flight);
      check({t, ".ovf"},   ovf, m_ovf);
      check({t, ".err"},   err, m_err);
      check({t, ".count"}, cnt, 16'(m_done));
      if (m_in_flight) begin
         check({t, ".adr"}, adr, e_adr);
         check({t, ".dat"}, dat, e_dat);
         check({t, ".sel"}, sel, 4'hF);
      end
   endtask

   initial forever begin
      @(negedge clk_memory);
      if (chk_en && !reset) begin
         cmp_dut("a", cyc_a, stb_a, we_a, adr_a, dat_a, sel_a, busy_a, ovf_a, err_a, cnt_a,
                 conv_adr(m_cur.addr, BASE_A), m_cur.data);
         cmp_dut("b", cyc_b, stb_b, we_b, adr_b, dat_b, sel_b, busy_b, ovf_b, err_b, cnt_b,
                 conv_adr(m_cur.addr, BASE_B), swap_bytes(m_cur.data));
         if (cyc_a && !prev_cyc) issued.push_back(dat_a);
         prev_cyc = cyc_a;
      end
   end

   // ---------------------------------------------------------------- slave
   bit hold      = 1'b0;
   bit force_err = 1'b0;
   bit err_en    = 1'b0;
   bit stray_en  = 1'b0;
   int max_delay = 0;
   int wait_left = 0;
   bit prev_cyc_s = 1'b0;

   initial forever begin
      @(negedge clk_memory);
      wb_ack = 1'b0;
      wb_err = 1'b0;
      if (cyc_a) begin
         if (!prev_cyc_s) wait_left = $urandom_range(0, max_delay);
         if (!hold) begin
            if (wait_left == 0) begin
               if (force_err) begin
                  wb_err    = 1'b1;
                  force_err = 1'b0;
               end else if (err_en && ($urandom_range(0, 7) == 0)) begin
                  wb_err = 1'b1;
                  wb_ack = 1'($urandom_range(0, 1));
               end else begin
                  wb_ack = 1'b1;
               end
               wait_left = $urandom_range(0, max_delay);
            end else begin
               wait_left--;
            end
         end
      end else if (stray_en) begin
         wb_ack = ($urandom_range(0, 3) == 0);
         wb_err = ($urandom_range(0, 7) == 0);
      end
      prev_cyc_s = cyc_a;
   end

   // ---------------------------------------------------------------- stimulus
   task automatic drive(input bit we, input logic [A_SZ-1:0] a, input logic [31:0] d);
      @(negedge clk_memory);
      write_en   = we;
      write_addr = a;
      write_data = d;
   endtask

   task automatic idle1();
      drive(1'b0, A_SZ'($urandom), $urandom);
   endtask

   task automatic check_zero(input string t);
      check({t, ".a.cyc"}, cyc_a, 0);   check({t, ".b.cyc"}, cyc_b, 0);
      check({t, ".a.stb"}, stb_a, 0);   check({t, ".b.stb"}, stb_b, 0);
      check({t, ".a.we"},  we_a, 0);    check({t, ".b.we"},  we_b, 0);
      check({t, ".a.adr"}, adr_a, 0);   check({t, ".b.adr"}, adr_b, 0);
      check({t, ".a.dat"}, dat_a, 0);   check({t, ".b.dat"}, dat_b, 0);
      check({t, ".a.sel"}, sel_a, 0);   check({t, ".b.sel"}, sel_b, 0);
      check({t, ".a.busy"}, busy_a, 0); check({t, ".b.busy"}, busy_b, 0);
      check({t, ".a.ovf"}, ovf_a, 0);   check({t, ".b.ovf"}, ovf_b, 0);
      check({t, ".a.err"}, err_a, 0);   check({t, ".b.err"}, err_b, 0);
      check({t, ".a.cnt"}, cnt_a, 0);   check({t, ".b.cnt"}, cnt_b, 0);
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge.
   task automatic reset_dut(input string t);
      @(negedge clk_memory);
      write_en = 1'b0;
      #2 reset = 1'b1;
      #1 check_zero(t);
      @(negedge clk_memory);
      reset = 1'b0;
   endtask

   task automatic wait_idle(input string t, input int limit);
      int k;
      k = 0;
      while (busy_a && (k < limit)) begin
         idle1();
         k++;
      end
      check({t, ".drained"}, busy_a, 0);
   endtask

   initial begin
      int hi;
      int k;
      int act;
      int pct;

      reset_dut("reset0");
      chk_en = 1'b1;

      // Single write: latency, conversion, completion.
      drive(1'b1, 28'h0000104, 32'hDEADBEEF);
      idle1();  check("lat.cyc_early", cyc_a, 0);
      idle1();
      check("w1.cyc",   cyc_a, 1);
      check("w1.adr_a", adr_a, 30'h41);
      check("w1.dat_a", dat_a, 32'hDEADBEEF);
      check("w1.sel_a", sel_a, 4'hF);
      check("w1.adr_b", adr_b, 30'h1041);
      check("w1.dat_b", dat_b, 32'hEFBEADDE);
      idle1();
      check("w1.cyc_done", cyc_a, 0);
      check("w1.count",    cnt_a, 1);
      check("w1.busy",     busy_a, 0);

      // Byte swap and base offset.
      drive(1'b1, 28'h0000008, 32'h11223344);
      idle1();
      idle1();
      check("w2.adr_a", adr_a, 30'h2);
      check("w2.dat_a", dat_a, 32'h11223344);
      check("w2.adr_b", adr_b, 30'h1002);
      check("w2.dat_b", dat_b, 32'h44332211);
      idle1();
      check("w2.count", cnt_b, 2);

      // Overflow: nine writes into an eight-deep buffer with the bus stalled.
      hold = 1'b1;
      issued.delete();
      for (int i = 0; i < 9; i++) drive(1'b1, A_SZ'(32'h200 + 4 * i), 32'hA0 + i);
      idle1();
      check("ovf.a", ovf_a, 1);
      check("ovf.b", ovf_b, 1);
      hold = 1'b0;
      wait_idle("ovf", 200);
      check("ovf.issued_n", issued.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < issued.size()) check($sformatf("ovf.issued%0d", i), issued[i], 32'hA0 + i);
      end
      check("ovf.count", cnt_a, 10);

      // Error on the first transaction, ack on the second.
      reset_dut("reset1");
      force_err = 1'b1;
      drive(1'b1, 28'h0000010, 32'h0BAD0001);
      drive(1'b1, 28'h0000014, 32'h600D0002);
      idle1();
      wait_idle("errp", 50);
      check("errp.error", err_a, 1);
      check("errp.count", cnt_a, 1);

      // Watchdog: the first transaction never gets a response.
      reset_dut("reset2");
      hold = 1'b1;
      drive(1'b1, 28'h0000020, 32'h7100_0001);
      drive(1'b1, 28'h0000024, 32'h7100_0002);
      k = 0;
      while (!cyc_a && (k < 10)) begin idle1(); k++; end
      hi = 0;
      if (cyc_a) hi = 1;
      for (int i = 0; i < 400; i++) begin
         idle1();
         if (!cyc_a) break;
         hi++;
      end
      check("tmo.cycles_high", hi, TMO);
      check("tmo.error",       err_a, 1);
      check("tmo.busy",        busy_a, 1);
      idle1();
      check("tmo.next_cyc",    cyc_a, 1);
      check("tmo.next_dat",    dat_a, 32'h7100_0002);
      hold = 1'b0;
      wait_idle("tmo", 20);
      check("tmo.count", cnt_a, 1);

      // Reset in the middle of a stalled transaction with a full buffer.
      hold = 1'b1;
      for (int i = 0; i < 10; i++) drive(1'b1, A_SZ'($urandom), $urandom);
      idle1();
      check("rmid.pre_ovf", ovf_a, 1);
      check("rmid.pre_cyc", cyc_a, 1);
      reset_dut("rmid");
      hold = 1'b0;
      act = 0;
      for (int i = 0; i < 20; i++) begin
         idle1();
         if (cyc_a || cyc_b) act++;
      end
      check("rmid.bus_activity", act, 0);

      // Random traffic with bursty density, response delays, errors and
      // stray responses while idle.
      reset_dut("reset3");
      max_delay = 3;
      err_en    = 1'b1;
      stray_en  = 1'b1;
      pct       = 50;
      for (int i = 0; i < 3000; i++) begin
         if ((i % 150) == 0) pct = $urandom_range(5, 95);
         drive(($urandom_range(0, 99) < pct), A_SZ'($urandom), $urandom);
      end
      stray_en = 1'b0;
      wait_idle("rand", 200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
